// File: rtl/bpf_front_check.sv
// bpf_front_check: registered BPU sanity checker; squashes false-taken predictions, redirects fetch, queues de-train updates.
// Define BPF_DIRECT_TGT_CHECK_EN to also correct wrong targets on predicted-taken direct branches.
module bpf_front_check #(
    parameter int FETCH_WIDTH = 2,
    parameter int UPD_DEPTH   = 4,
    parameter int LPHR_W      = 5,
    parameter int LPHR_IDX_W  = 10,
    localparam int SLOT_W     = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [31:0]               pc_i,
    input  logic [FETCH_WIDTH-1:0]    slot_vld_i,
    input  logic [FETCH_WIDTH-1:0]    is_br_i,
    input  logic [32*FETCH_WIDTH-1:0] br_tgt_i,
    input  logic [FETCH_WIDTH-1:0]    is_direct_i,
    input  logic                      pred_taken_i,
    input  logic [SLOT_W-1:0]         pred_slot_i,
    input  logic [31:0]               pred_npc_i,
    input  logic [LPHR_W-1:0]         pred_lphr_i,
    input  logic [LPHR_IDX_W-1:0]     pred_lidx_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_taken_o,
    output logic [31:0]               out_npc_o,
    output logic                      redirect_o,
    output logic [31:0]               redirect_pc_o,
    output logic                      upd_valid_o,
    input  logic                      upd_ready_i,
    output logic [31:0]               upd_pc_o,
    output logic [31:0]               upd_tgt_o,
    output logic [LPHR_W-1:0]         upd_lphr_o,
    output logic [LPHR_IDX_W-1:0]     upd_lidx_o,
    output logic [15:0]               fix_cnt_o
);
    localparam int PTR_W = $clog2(UPD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] GRP_B = 32'(FETCH_WIDTH * 4);

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           tgt;
        logic [LPHR_W-1:0]     lphr;
        logic [LPHR_IDX_W-1:0] lidx;
    } upd_t;

    logic                  out_valid_q, out_valid_d, out_taken_q, out_taken_d;
    logic                  redirect_q, redirect_d;
    logic [31:0]           out_npc_q, out_npc_d, redirect_pc_q, redirect_pc_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [15:0]           fix_cnt_q, fix_cnt_d;
    upd_t                  mem_q [UPD_DEPTH];
    upd_t                  mem_d [UPD_DEPTH];
    upd_t                  head_q, head_d, new_ent;
    logic                  sel_vld, sel_br, false_taken, tgt_fault, fault, accept, push, pop;
    logic [31:0]           fallthru, fix_tgt;

    // A slot index beyond FETCH_WIDTH never matches, so it reads as an empty slot and faults.
`ifdef BPF_DIRECT_TGT_CHECK_EN
    logic                  sel_dir;
    logic [31:0]           sel_tgt;
    always_comb begin
        sel_vld = 1'b0;
        sel_br  = 1'b0;
        sel_dir = 1'b0;
        sel_tgt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (32'(pred_slot_i) == i) begin
                sel_vld = slot_vld_i[i];
                sel_br  = is_br_i[i];
                sel_dir = is_direct_i[i];
                sel_tgt = br_tgt_i[32*i +: 32];
            end
        end
    end
    assign tgt_fault = pred_taken_i & ~false_taken & sel_dir & (sel_tgt != pred_npc_i);
    assign fix_tgt   = false_taken ? fallthru : sel_tgt;
`else
    logic unused_direct;
    always_comb begin
        sel_vld = 1'b0;
        sel_br  = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (32'(pred_slot_i) == i) begin
                sel_vld = slot_vld_i[i];
                sel_br  = is_br_i[i];
            end
        end
    end
    assign unused_direct = ^{br_tgt_i, is_direct_i};
    assign tgt_fault     = 1'b0;
    assign fix_tgt       = fallthru;
`endif

    assign fallthru    = (pc_i & ~(GRP_B - 32'd1)) + GRP_B;
    assign false_taken = pred_taken_i & ~(sel_vld & sel_br);
    assign fault       = false_taken | tgt_fault;
    assign in_ready_o  = (~out_valid_q | out_ready_i) & (32'(count_q) < UPD_DEPTH) & ~flush_i;
    assign accept      = in_valid_i & in_ready_o;
    assign push        = accept & fault;
    assign upd_valid_o = count_q != '0;
    assign pop         = upd_valid_o & upd_ready_i;
    assign new_ent     = '{pc: pc_i, tgt: fix_tgt, lphr: pred_lphr_i, lidx: pred_lidx_i};

    always_comb begin
        out_valid_d   = out_valid_q;
        out_taken_d   = out_taken_q;
        out_npc_d     = out_npc_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_taken_d = fault ? tgt_fault : pred_taken_i;
            out_npc_d   = fault ? fix_tgt : pred_npc_i;
            redirect_d  = fault;
            if (fault) redirect_pc_d = fix_tgt;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        fix_cnt_d = (push && fix_cnt_q != 16'hFFFF) ? fix_cnt_q + 16'd1 : fix_cnt_q;
        mem_d     = mem_q;
        if (push) mem_d[wr_ptr_q] = new_ent;
        // Head register reads through the write, so a push into an empty FIFO is visible next cycle.
        head_d    = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_taken_q   <= 1'b0;
            out_npc_q     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fix_cnt_q     <= '0;
            mem_q         <= '{default: '0};
            head_q        <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_taken_q   <= out_taken_d;
            out_npc_q     <= out_npc_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fix_cnt_q     <= fix_cnt_d;
            mem_q         <= mem_d;
            head_q        <= head_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_taken_o   = out_taken_q;
    assign out_npc_o     = out_npc_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign upd_pc_o      = head_q.pc;
    assign upd_tgt_o     = head_q.tgt;
    assign upd_lphr_o    = head_q.lphr;
    assign upd_lidx_o    = head_q.lidx;
    assign fix_cnt_o     = fix_cnt_q;
endmodule

// File: tb/tb_bpf_front_check.sv
// tb_bpf_front_check: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_bpf_front_check;
    localparam int FW = 2, DEPTH = 4, LW = 5, LIW = 10;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic flush_i, in_valid_i, in_ready_o, pred_taken_i, out_valid_o, out_ready_i, out_taken_o;
    logic redirect_o, upd_valid_o, upd_ready_i;
    logic [31:0] pc_i, pred_npc_i, out_npc_o, redirect_pc_o, upd_pc_o, upd_tgt_o;
    logic [FW-1:0] slot_vld_i, is_br_i, is_direct_i;
    logic [32*FW-1:0] br_tgt_i;
    logic [0:0] pred_slot_i;
    logic [LW-1:0] pred_lphr_i, upd_lphr_o;
    logic [LIW-1:0] pred_lidx_i, upd_lidx_o;
    logic [15:0] fix_cnt_o;

    bpf_front_check dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .slot_vld_i(slot_vld_i), .is_br_i(is_br_i), .br_tgt_i(br_tgt_i),
        .is_direct_i(is_direct_i), .pred_taken_i(pred_taken_i), .pred_slot_i(pred_slot_i),
        .pred_npc_i(pred_npc_i), .pred_lphr_i(pred_lphr_i), .pred_lidx_i(pred_lidx_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_taken_o(out_taken_o),
        .out_npc_o(out_npc_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o),
        .upd_tgt_o(upd_tgt_o), .upd_lphr_o(upd_lphr_o), .upd_lidx_o(upd_lidx_o), .fix_cnt_o(fix_cnt_o)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0]    pc;
        logic [31:0]    tgt;
        logic [LW-1:0]  lphr;
        logic [LIW-1:0] lidx;
    } upd_t;

    upd_t        q[$];
    logic        m_vld, m_taken, m_redir;
    logic [31:0] m_npc, m_rpc;
    int          m_fix;

    task automatic model_reset();
        q.delete();
        m_vld = 0; m_taken = 0; m_redir = 0; m_npc = 0; m_rpc = 0; m_fix = 0;
    endtask

    function automatic logic exp_ready();
        return (!m_vld || out_ready_i) && q.size() < DEPTH && !flush_i;
    endfunction

    task automatic check_out();
        chk("out_valid", 32'(out_valid_o), 32'(m_vld));
        if (m_vld) begin
            chk("out_taken", 32'(out_taken_o), 32'(m_taken));
            chk("out_npc", out_npc_o, m_npc);
        end
        chk("redirect", 32'(redirect_o), 32'(m_redir));
        if (m_redir) chk("redirect_pc", redirect_pc_o, m_rpc);
        chk("upd_valid", 32'(upd_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("upd_pc", upd_pc_o, q[0].pc);
            chk("upd_tgt", upd_tgt_o, q[0].tgt);
            chk("upd_lphr", 32'(upd_lphr_o), 32'(q[0].lphr));
            chk("upd_lidx", 32'(upd_lidx_o), 32'(q[0].lidx));
        end
        chk("fix_cnt", 32'(fix_cnt_o), 32'(m_fix));
        chk("in_ready", 32'(in_ready_o), 32'(exp_ready()));
    endtask

    task automatic model_step();
        logic        rdy, acc, ft_fault, dir_fault, flt;
        logic [31:0] ft, tgt;
        int          s;
        upd_t        e;
        rdy = exp_ready();
        acc = in_valid_i && rdy;
        s = int'(pred_slot_i);
        ft = 32'((longint'(pc_i) / (FW * 4) + 1) * (FW * 4));
        ft_fault = pred_taken_i && (s >= FW || !slot_vld_i[s] || !is_br_i[s]);
        dir_fault = 0;
        tgt = ft;
`ifdef BPF_DIRECT_TGT_CHECK_EN
        if (!ft_fault && pred_taken_i && is_direct_i[s] && br_tgt_i[s*32 +: 32] != pred_npc_i) begin
            dir_fault = 1;
            tgt = br_tgt_i[s*32 +: 32];
        end
`endif
        flt = ft_fault || dir_fault;
        if (q.size() != 0 && upd_ready_i) void'(q.pop_front());
        if (acc && flt) begin
            e.pc = pc_i; e.tgt = tgt; e.lphr = pred_lphr_i; e.lidx = pred_lidx_i;
            q.push_back(e);
            if (m_fix < 65535) m_fix++;
        end
        if (flush_i) begin
            m_vld = 0; m_redir = 0;
        end else if (acc) begin
            m_vld = 1;
            m_taken = flt ? dir_fault : pred_taken_i;
            m_npc = flt ? tgt : pred_npc_i;
            m_redir = flt;
            m_rpc = tgt;
        end else begin
            if (out_ready_i) m_vld = 0;
            m_redir = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_out();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_grp(input logic [31:0] pc, input logic tk, input logic sl, input logic [1:0] vld,
                           input logic [1:0] br, input logic [31:0] npc);
        in_valid_i = 1; pc_i = pc; pred_taken_i = tk; pred_slot_i = sl;
        slot_vld_i = vld; is_br_i = br; pred_npc_i = npc;
        pred_lphr_i = LW'($urandom); pred_lidx_i = LIW'($urandom);
    endtask

    task automatic idle();
        flush_i = 0; in_valid_i = 0; pc_i = 0; slot_vld_i = 0; is_br_i = 0; br_tgt_i = 0;
        is_direct_i = 0; pred_taken_i = 0; pred_slot_i = 0; pred_npc_i = 0; pred_lphr_i = 0;
        pred_lidx_i = 0; out_ready_i = 1; upd_ready_i = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 0);
        chk({tag, "_redirect"}, 32'(redirect_o), 0);
        chk({tag, "_upd_valid"}, 32'(upd_valid_o), 0);
        chk({tag, "_fix_cnt"}, 32'(fix_cnt_o), 0);
        chk({tag, "_out_npc"}, out_npc_o, 0);
        chk({tag, "_upd_pc"}, upd_pc_o, 0);
    endtask

    task automatic randomize_inputs(input int up_pct);
        flush_i = $urandom_range(99) < 5;
        in_valid_i = $urandom_range(99) < 70;
        out_ready_i = $urandom_range(99) < 70;
        upd_ready_i = $urandom_range(99) < up_pct;
        pc_i = ($urandom_range(15) == 0) ? 32'hFFFF_FFF8 | ($urandom & 32'h4) : $urandom;
        pred_taken_i = $urandom_range(99) < 60;
        pred_slot_i = 1'($urandom);
        slot_vld_i = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
        is_br_i = 2'($urandom);
        is_direct_i = 2'($urandom);
        pred_npc_i = $urandom;
        br_tgt_i = {$urandom, $urandom};
        if ($urandom_range(1) == 0) br_tgt_i[int'(pred_slot_i)*32 +: 32] = pred_npc_i;
        pred_lphr_i = LW'($urandom);
        pred_lidx_i = LIW'($urandom);
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_reset("rst");
        @(posedge clk); #1;
        rst_n = 1;

        // 1: false-taken slot1 redirects to fall-through
        set_grp(32'h1C00_0000, 1, 1, 2'b11, 2'b01, 32'h1C00_0080);
        cycle();
        idle();
        chk("t1_redirect", 32'(redirect_o), 1);
        chk("t1_redirect_pc", redirect_pc_o, 32'h1C00_0008);
        chk("t1_out_taken", 32'(out_taken_o), 0);
        chk("t1_upd_valid", 32'(upd_valid_o), 1);

        // 2: correct prediction passes through
        set_grp(32'h1C00_0010, 1, 0, 2'b11, 2'b01, 32'h1C00_0040);
        upd_ready_i = 1;
        cycle();
        idle();
        chk("t2_redirect", 32'(redirect_o), 0);
        chk("t2_out_npc", out_npc_o, 32'h1C00_0040);
        chk("t2_upd_valid", 32'(upd_valid_o), 0);
        chk("t2_fix_cnt", 32'(fix_cnt_o), 1);

        // 3: fill FIFO with stalled BPU, then one pop reopens input
        for (int i = 0; i < 4; i++) begin
            set_grp(32'h2000_0000 + 32'(i * 8), 1, 0, 2'b10, 2'b11, 32'h0);
            cycle();
        end
        chk("t3_in_ready_full", 32'(in_ready_o), 0);
        in_valid_i = 0; upd_ready_i = 1;
        cycle();
        chk("t3_in_ready_pop", 32'(in_ready_o), 1);
        for (int i = 0; i < 3; i++) cycle();
        idle();

        // 4: fall-through wraps past the top of memory
        set_grp(32'hFFFF_FFF8, 1, 1, 2'b01, 2'b11, 32'h1234_5678);
        cycle();
        idle();
        chk("t4_redirect_pc", redirect_pc_o, 32'h0);
        chk("t4_upd_tgt", upd_tgt_o, 32'h0);

        // 5: flush blocks a faulting group and leaves training intact
        set_grp(32'h3000_0000, 1, 1, 2'b11, 2'b01, 32'h0);
        flush_i = 1;
        cycle();
        idle();
        chk("t5_out_valid", 32'(out_valid_o), 0);
        chk("t5_redirect", 32'(redirect_o), 0);
        chk("t5_upd_pc", upd_pc_o, 32'hFFFF_FFF8);
        chk("t5_fix_cnt", 32'(fix_cnt_o), 6);
        upd_ready_i = 1;
        cycle();
        idle();

`ifdef BPF_DIRECT_TGT_CHECK_EN
        // 6: wrong direct target is corrected and stays taken
        set_grp(32'h1C00_0000, 1, 0, 2'b11, 2'b11, 32'h1C00_0200);
        is_direct_i = 2'b01;
        br_tgt_i = {32'h0, 32'h1C00_0100};
        upd_ready_i = 1;
        cycle();
        idle();
        chk("t6_redirect", 32'(redirect_o), 1);
        chk("t6_redirect_pc", redirect_pc_o, 32'h1C00_0100);
        chk("t6_out_taken", 32'(out_taken_o), 1);
`endif

        for (int n = 0; n < 3000; n++) begin
            randomize_inputs(((n / 64) % 2 == 0) ? 15 : 80);
            cycle();
        end

        // asynchronous reset in the middle of traffic
        randomize_inputs(50);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_reset("mid_rst");
        idle();
        @(posedge clk); #1;
        rst_n = 1;
        for (int n = 0; n < 1000; n++) begin
            randomize_inputs(50);
            cycle();
        end
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
